// File: rtl/ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
// Shared control-path types for the RV32I 5-stage pipeline control unit.
//   - RV32I opcode constants
//   - alu_ctrl_t, imm_src_t, result_src_t, pc_src_t encodings
//   - ctrl_bundle_t: control carried from ID into EX (and partly onward)
//   - CTRL_BUBBLE: the all-zero bundle used for flushes, stalls and reset
//   - alu_op_sel(): funct3 (+ alternate bit) to ALU operation
// -----------------------------------------------------------------------------
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_ctrl_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_TARGET = 2'b01,
    PC_ALU    = 2'b10
  } pc_src_t;

  // jalr is kept as its own flag: jal and jalr both jump, but only jalr
  // takes its target from the ALU.
  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    result_src_t result_src;
    logic        alu_src;
    logic        alu_a_pc;
    alu_ctrl_t   alu_ctrl;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic [2:0]  funct3;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

  // funct3 to ALU op; alt selects sub (000) or sra (101).
  function automatic alu_ctrl_t alu_op_sel(input logic [2:0] f3, input logic alt);
    alu_ctrl_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// -----------------------------------------------------------------------------
// ctrl_decoder
// Combinational RV32I decode of the ID-stage instruction.
// Ports:
//   i_instr    in  32  instruction in ID
//   o_ctrl     out     control bundle (bubble when illegal)
//   o_imm_src  out  3  immediate format for the ID extender
//   o_uses_rs1 out  1  instruction reads rs1
//   o_uses_rs2 out  1  instruction reads rs2
//   o_illegal  out  1  opcode or branch funct3 unsupported
// -----------------------------------------------------------------------------
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [31:0]  i_instr,
  output ctrl_bundle_t o_ctrl,
  output imm_src_t     o_imm_src,
  output logic         o_uses_rs1,
  output logic         o_uses_rs2,
  output logic         o_illegal
);

  logic [6:0]   w_opcode;
  logic [2:0]   w_funct3;
  logic         w_funct7_b5;
  ctrl_bundle_t w_ctrl;
  imm_src_t     w_imm_src;
  logic         w_use1;
  logic         w_use2;
  logic         w_bad;

  assign w_opcode    = i_instr[6:0];
  assign w_funct3    = i_instr[14:12];
  assign w_funct7_b5 = i_instr[30];

  // Per-opcode decode before illegal masking
  always_comb begin
    w_ctrl        = CTRL_BUBBLE;
    w_ctrl.funct3 = w_funct3;
    w_imm_src     = IMM_I;
    w_use1        = 1'b0;
    w_use2        = 1'b0;
    w_bad         = 1'b0;
    case (w_opcode)
      OP_LOAD: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.result_src = RES_MEM;
        w_ctrl.alu_src    = 1'b1;
        w_use1            = 1'b1;
      end
      OP_STORE: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_imm_src        = IMM_S;
        w_use1           = 1'b1;
        w_use2           = 1'b1;
      end
      OP_RTYPE: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_ctrl  = alu_op_sel(w_funct3, w_funct7_b5);
        w_use1           = 1'b1;
        w_use2           = 1'b1;
      end
      OP_ITYPE: begin
        // instr[30] is an immediate bit except for srai, so no "subi".
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_ctrl  = alu_op_sel(w_funct3, w_funct7_b5 & (w_funct3 == 3'b101));
        w_use1           = 1'b1;
      end
      OP_BRANCH: begin
        w_ctrl.branch   = 1'b1;
        w_ctrl.alu_ctrl = ALU_SUB;
        w_imm_src       = IMM_B;
        w_use1          = 1'b1;
        w_use2          = 1'b1;
        case (w_funct3)
          3'b010, 3'b011: w_bad = 1'b1;
          default:        w_bad = 1'b0;
        endcase
      end
      OP_LUI: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_ctrl  = ALU_PASSB;
        w_imm_src        = IMM_U;
      end
      OP_AUIPC: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_a_pc  = 1'b1;
        w_imm_src        = IMM_U;
      end
      OP_JAL: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.result_src = RES_PC4;
        w_ctrl.jump       = 1'b1;
        w_imm_src         = IMM_J;
      end
      OP_JALR: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.result_src = RES_PC4;
        w_ctrl.jump       = 1'b1;
        w_ctrl.jalr       = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_use1            = 1'b1;
      end
      default: w_bad = 1'b1;
    endcase
  end

  // Illegal instructions become bubbles and read no registers (never stall)
  always_comb begin
    if (w_bad) begin
      o_ctrl     = CTRL_BUBBLE;
      o_imm_src  = IMM_I;
      o_uses_rs1 = 1'b0;
      o_uses_rs2 = 1'b0;
    end else begin
      o_ctrl     = w_ctrl;
      o_imm_src  = w_imm_src;
      o_uses_rs1 = w_use1;
      o_uses_rs2 = w_use2;
    end
    o_illegal = w_bad;
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// -----------------------------------------------------------------------------
// pipelined_control_unit
// RV32I control for a 5-stage pipeline: ID decode, ID/EX, EX/MEM and MEM/WB
// control registers, EX branch/jump resolution, load-use hazard detection
// and forwarding selection.
// Ports:
//   clk, rst (sync, active-high)
//   instr_d_i             ID instruction
//   zero_e_i/lt_e_i/ltu_e_i  EX compare flags
//   imm_src_d_o, illegal_d_o                      ID outputs
//   alu_src_e_o, alu_a_pc_e_o, alu_ctrl_e_o,
//   pc_src_e_o, forward_a_e_o, forward_b_e_o      EX outputs
//   mem_write_m_o, reg_write_m_o, rd_m_o          MEM outputs
//   result_src_w_o, reg_write_w_o, rd_w_o         WB outputs
//   stall_f_o, stall_d_o, flush_d_o               hazard controls
// -----------------------------------------------------------------------------
module pipelined_control_unit
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr_d_i,
  input  logic                  zero_e_i,
  input  logic                  lt_e_i,
  input  logic                  ltu_e_i,
  output logic [2:0]            imm_src_d_o,
  output logic                  illegal_d_o,
  output logic                  alu_src_e_o,
  output logic                  alu_a_pc_e_o,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_e_o,
  output logic [1:0]            pc_src_e_o,
  output logic [1:0]            forward_a_e_o,
  output logic [1:0]            forward_b_e_o,
  output logic                  mem_write_m_o,
  output logic                  reg_write_m_o,
  output logic [REG_ADDR_W-1:0] rd_m_o,
  output logic [1:0]            result_src_w_o,
  output logic                  reg_write_w_o,
  output logic [REG_ADDR_W-1:0] rd_w_o,
  output logic                  stall_f_o,
  output logic                  stall_d_o,
  output logic                  flush_d_o
);

  // ID stage
  ctrl_bundle_t          w_ctrl_d;
  imm_src_t              w_imm_src_d;
  logic                  w_uses_rs1_d;
  logic                  w_uses_rs2_d;
  logic                  w_illegal_d;
  logic [REG_ADDR_W-1:0] w_rs1_d;
  logic [REG_ADDR_W-1:0] w_rs2_d;
  logic [REG_ADDR_W-1:0] w_rd_d;

  // EX stage
  ctrl_bundle_t          r_ctrl_e;
  logic [REG_ADDR_W-1:0] r_rs1_e;
  logic [REG_ADDR_W-1:0] r_rs2_e;
  logic [REG_ADDR_W-1:0] r_rd_e;

  // MEM stage
  logic                  r_reg_write_m;
  logic                  r_mem_write_m;
  result_src_t           r_result_src_m;
  logic [REG_ADDR_W-1:0] r_rd_m;

  // WB stage
  logic                  r_reg_write_w;
  result_src_t           r_result_src_w;
  logic [REG_ADDR_W-1:0] r_rd_w;

  // Hazard / resolve
  logic                  w_cond_e;
  pc_src_t               w_pc_src_e;
  logic                  w_redirect_e;
  logic                  w_load_use;
  logic                  w_stall;
  logic                  w_flush_e;
  logic [1:0]            w_fwd_a;
  logic [1:0]            w_fwd_b;

  assign w_rs1_d = instr_d_i[15 +: REG_ADDR_W];
  assign w_rs2_d = instr_d_i[20 +: REG_ADDR_W];
  assign w_rd_d  = instr_d_i[7  +: REG_ADDR_W];

  ctrl_decoder u_decoder (
    .i_instr    (instr_d_i),
    .o_ctrl     (w_ctrl_d),
    .o_imm_src  (w_imm_src_d),
    .o_uses_rs1 (w_uses_rs1_d),
    .o_uses_rs2 (w_uses_rs2_d),
    .o_illegal  (w_illegal_d)
  );

  // Branch condition from funct3 and the EX compare flags
  always_comb begin
    w_cond_e = 1'b0;
    case (r_ctrl_e.funct3)
      3'b000:  w_cond_e = zero_e_i;
      3'b001:  w_cond_e = ~zero_e_i;
      3'b100:  w_cond_e = lt_e_i;
      3'b101:  w_cond_e = ~lt_e_i;
      3'b110:  w_cond_e = ltu_e_i;
      3'b111:  w_cond_e = ~ltu_e_i;
      default: w_cond_e = 1'b0;
    endcase
  end

  // Next-PC select; held at pc+4 during reset so no redirect escapes
  always_comb begin
    w_pc_src_e = PC_PLUS4;
    if (rst) begin
      w_pc_src_e = PC_PLUS4;
    end else if (r_ctrl_e.jalr) begin
      w_pc_src_e = PC_ALU;
    end else if (r_ctrl_e.jump | (r_ctrl_e.branch & w_cond_e)) begin
      w_pc_src_e = PC_TARGET;
    end else begin
      w_pc_src_e = PC_PLUS4;
    end
  end

  assign w_redirect_e = (w_pc_src_e != PC_PLUS4);

  // Load in EX whose rd is read by the ID instruction; x0 never stalls
  assign w_load_use = (r_ctrl_e.result_src == RES_MEM) && (r_rd_e != '0) &&
                      ((w_uses_rs1_d && (w_rs1_d == r_rd_e)) ||
                       (w_uses_rs2_d && (w_rs2_d == r_rd_e)));

  // A taken redirect squashes the ID instruction, so the stall is moot.
  assign w_stall   = ~rst & w_load_use & ~w_redirect_e;
  assign w_flush_e = w_load_use | w_redirect_e;

  // Forwarding select; MEM result is younger so it wins over WB
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (rst) begin
      w_fwd_a = 2'b00;
      w_fwd_b = 2'b00;
    end else begin
      if (r_reg_write_m && (r_rd_m != '0) && (r_rd_m == r_rs1_e)) begin
        w_fwd_a = 2'b10;
      end else if (r_reg_write_w && (r_rd_w != '0) && (r_rd_w == r_rs1_e)) begin
        w_fwd_a = 2'b01;
      end else begin
        w_fwd_a = 2'b00;
      end
      if (r_reg_write_m && (r_rd_m != '0) && (r_rd_m == r_rs2_e)) begin
        w_fwd_b = 2'b10;
      end else if (r_reg_write_w && (r_rd_w != '0) && (r_rd_w == r_rs2_e)) begin
        w_fwd_b = 2'b01;
      end else begin
        w_fwd_b = 2'b00;
      end
    end
  end

  // ID/EX register: loads the decoded bundle, or a bubble on flush
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl_e <= CTRL_BUBBLE;
      r_rs1_e  <= '0;
      r_rs2_e  <= '0;
      r_rd_e   <= '0;
    end else if (w_flush_e) begin
      r_ctrl_e <= CTRL_BUBBLE;
      r_rs1_e  <= '0;
      r_rs2_e  <= '0;
      r_rd_e   <= '0;
    end else begin
      r_ctrl_e <= w_ctrl_d;
      r_rs1_e  <= w_rs1_d;
      r_rs2_e  <= w_rs2_d;
      r_rd_e   <= w_rd_d;
    end
  end

  // EX/MEM register: advances every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg_write_m  <= 1'b0;
      r_mem_write_m  <= 1'b0;
      r_result_src_m <= RES_ALU;
      r_rd_m         <= '0;
    end else begin
      r_reg_write_m  <= r_ctrl_e.reg_write;
      r_mem_write_m  <= r_ctrl_e.mem_write;
      r_result_src_m <= r_ctrl_e.result_src;
      r_rd_m         <= r_rd_e;
    end
  end

  // MEM/WB register: advances every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg_write_w  <= 1'b0;
      r_result_src_w <= RES_ALU;
      r_rd_w         <= '0;
    end else begin
      r_reg_write_w  <= r_reg_write_m;
      r_result_src_w <= r_result_src_m;
      r_rd_w         <= r_rd_m;
    end
  end

  assign imm_src_d_o    = w_imm_src_d;
  assign illegal_d_o    = w_illegal_d;
  assign alu_src_e_o    = r_ctrl_e.alu_src;
  assign alu_a_pc_e_o   = r_ctrl_e.alu_a_pc;
  assign alu_ctrl_e_o   = r_ctrl_e.alu_ctrl;
  assign pc_src_e_o     = w_pc_src_e;
  assign forward_a_e_o  = w_fwd_a;
  assign forward_b_e_o  = w_fwd_b;
  assign mem_write_m_o  = r_mem_write_m;
  assign reg_write_m_o  = r_reg_write_m;
  assign rd_m_o         = r_rd_m;
  assign result_src_w_o = r_result_src_w;
  assign reg_write_w_o  = r_reg_write_w;
  assign rd_w_o         = r_rd_w;
  assign stall_f_o      = w_stall;
  assign stall_d_o      = w_stall;
  assign flush_d_o      = w_redirect_e;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// -----------------------------------------------------------------------------
// Self-checking bench for pipelined_control_unit. Instructions are generated
// as mnemonic-level records, encoded to bits for the DUT, and the expected
// behaviour is derived from the records by a stage-slot reference model.
// -----------------------------------------------------------------------------
module tb_pipelined_control_unit;
  import ctrl_pkg::*;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_B = 4, K_LUI = 5;
  localparam int K_AUIPC = 6, K_JAL = 7, K_JALR = 8, K_BAD = 9, K_NONE = 10;

  typedef struct {
    int         kind;
    logic [2:0] f3;
    logic       f7b;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } op_t;

  typedef struct {
    logic       rw;
    logic       mw;
    logic [1:0] rsrc;
    logic       asrc;
    logic       apc;
    logic [3:0] alu;
    int         kind;
    logic [2:0] f3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } slot_t;

  logic        clk;
  logic        rst;
  logic [31:0] instr_d_i;
  logic        zero_e_i, lt_e_i, ltu_e_i;
  logic [2:0]  imm_src_d_o;
  logic        illegal_d_o, alu_src_e_o, alu_a_pc_e_o;
  logic [3:0]  alu_ctrl_e_o;
  logic [1:0]  pc_src_e_o, forward_a_e_o, forward_b_e_o;
  logic        mem_write_m_o, reg_write_m_o;
  logic [4:0]  rd_m_o;
  logic [1:0]  result_src_w_o;
  logic        reg_write_w_o;
  logic [4:0]  rd_w_o;
  logic        stall_f_o, stall_d_o, flush_d_o;

  slot_t m_ex, m_mem, m_wb;
  int    n_checks = 0;
  int    n_pass   = 0;
  logic  exp_stall_last;
  logic [1:0] obs_pc;
  logic  obs_flush, obs_stall, obs_illegal;

  pipelined_control_unit dut (
    .clk(clk), .rst(rst), .instr_d_i(instr_d_i),
    .zero_e_i(zero_e_i), .lt_e_i(lt_e_i), .ltu_e_i(ltu_e_i),
    .imm_src_d_o(imm_src_d_o), .illegal_d_o(illegal_d_o),
    .alu_src_e_o(alu_src_e_o), .alu_a_pc_e_o(alu_a_pc_e_o),
    .alu_ctrl_e_o(alu_ctrl_e_o), .pc_src_e_o(pc_src_e_o),
    .forward_a_e_o(forward_a_e_o), .forward_b_e_o(forward_b_e_o),
    .mem_write_m_o(mem_write_m_o), .reg_write_m_o(reg_write_m_o),
    .rd_m_o(rd_m_o), .result_src_w_o(result_src_w_o),
    .reg_write_w_o(reg_write_w_o), .rd_w_o(rd_w_o),
    .stall_f_o(stall_f_o), .stall_d_o(stall_d_o), .flush_d_o(flush_d_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic op_t mk(input int k, input logic [2:0] f3, input logic f7b,
                             input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    op_t o;
    o.kind = k; o.f3 = f3; o.f7b = f7b; o.rd = rd; o.rs1 = rs1; o.rs2 = rs2;
    return o;
  endfunction

  function automatic logic [31:0] encode(input op_t op);
    logic [6:0] opc;
    case (op.kind)
      K_LW:    opc = 7'b0000011;
      K_SW:    opc = 7'b0100011;
      K_R:     opc = 7'b0110011;
      K_I:     opc = 7'b0010011;
      K_B:     opc = 7'b1100011;
      K_LUI:   opc = 7'b0110111;
      K_AUIPC: opc = 7'b0010111;
      K_JAL:   opc = 7'b1101111;
      K_JALR:  opc = 7'b1100111;
      default: opc = op.f7b ? 7'b1111111 : 7'b0000000;
    endcase
    return {1'b0, op.f7b, 5'b00000, op.rs2, op.rs1, op.f3, op.rd, opc};
  endfunction

  function automatic logic is_illegal(input op_t op);
    return (op.kind == K_BAD) || (op.kind == K_B && (op.f3 == 3'd2 || op.f3 == 3'd3));
  endfunction

  function automatic logic reads_rs1(input op_t op);
    return !is_illegal(op) && op.kind != K_LUI && op.kind != K_AUIPC && op.kind != K_JAL;
  endfunction

  function automatic logic reads_rs2(input op_t op);
    return !is_illegal(op) && (op.kind == K_R || op.kind == K_SW || op.kind == K_B);
  endfunction

  // RV32I arithmetic meaning of funct3 (alt = sub/sra form)
  function automatic logic [3:0] arith(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? 4'(ALU_SUB) : 4'(ALU_ADD);
      3'd1:    return 4'(ALU_SLL);
      3'd2:    return 4'(ALU_SLT);
      3'd3:    return 4'(ALU_SLTU);
      3'd4:    return 4'(ALU_XOR);
      3'd5:    return alt ? 4'(ALU_SRA) : 4'(ALU_SRL);
      3'd6:    return 4'(ALU_OR);
      default: return 4'(ALU_AND);
    endcase
  endfunction

  function automatic logic [2:0] exp_imm(input op_t op);
    if (is_illegal(op)) return 3'(IMM_I);
    case (op.kind)
      K_SW:           return 3'(IMM_S);
      K_B:            return 3'(IMM_B);
      K_JAL:          return 3'(IMM_J);
      K_LUI, K_AUIPC: return 3'(IMM_U);
      default:        return 3'(IMM_I);
    endcase
  endfunction

  function automatic slot_t bubble();
    slot_t s;
    s.rw = 1'b0; s.mw = 1'b0; s.rsrc = 2'd0; s.asrc = 1'b0; s.apc = 1'b0;
    s.alu = 4'd0; s.kind = K_NONE; s.f3 = 3'd0;
    s.rs1 = 5'd0; s.rs2 = 5'd0; s.rd = 5'd0;
    return s;
  endfunction

  function automatic slot_t to_slot(input op_t op);
    slot_t s;
    s = bubble();
    s.kind = is_illegal(op) ? K_BAD : op.kind;
    s.f3 = op.f3; s.rs1 = op.rs1; s.rs2 = op.rs2; s.rd = op.rd;
    case (s.kind)
      K_LW:    begin s.rw = 1'b1; s.rsrc = 2'd1; s.asrc = 1'b1; end
      K_SW:    begin s.mw = 1'b1; s.asrc = 1'b1; end
      K_R:     begin s.rw = 1'b1; s.alu = arith(op.f3, op.f7b); end
      K_I:     begin s.rw = 1'b1; s.asrc = 1'b1; s.alu = arith(op.f3, op.f7b && op.f3 == 3'd5); end
      K_B:     s.alu = 4'(ALU_SUB);
      K_LUI:   begin s.rw = 1'b1; s.asrc = 1'b1; s.alu = 4'(ALU_PASSB); end
      K_AUIPC: begin s.rw = 1'b1; s.asrc = 1'b1; s.apc = 1'b1; end
      K_JAL:   begin s.rw = 1'b1; s.rsrc = 2'd2; end
      K_JALR:  begin s.rw = 1'b1; s.rsrc = 2'd2; s.asrc = 1'b1; end
      default: s.rw = 1'b0;
    endcase
    return s;
  endfunction

  function automatic logic [1:0] fwd(input logic [4:0] r);
    if (m_mem.rw && m_mem.rd != 5'd0 && m_mem.rd == r) return 2'b10;
    if (m_wb.rw && m_wb.rd != 5'd0 && m_wb.rd == r) return 2'b01;
    return 2'b00;
  endfunction

  // Present one ID instruction for a cycle, compare every output, advance model
  task automatic step(input op_t op, input logic z, input logic lt, input logic ltu);
    logic taken, lu, redirect;
    logic [1:0] pcs;
    instr_d_i = encode(op);
    zero_e_i = z; lt_e_i = lt; ltu_e_i = ltu;
    #1;
    taken = 1'b0;
    if (m_ex.kind == K_B) begin
      case (m_ex.f3)
        3'd0:    taken = z;
        3'd1:    taken = !z;
        3'd4:    taken = lt;
        3'd5:    taken = !lt;
        3'd6:    taken = ltu;
        3'd7:    taken = !ltu;
        default: taken = 1'b0;
      endcase
    end
    pcs = (m_ex.kind == K_JALR) ? 2'b10 : ((m_ex.kind == K_JAL || taken) ? 2'b01 : 2'b00);
    redirect = (pcs != 2'b00);
    lu = (m_ex.rsrc == 2'd1) && (m_ex.rd != 5'd0) &&
         ((reads_rs1(op) && op.rs1 == m_ex.rd) || (reads_rs2(op) && op.rs2 == m_ex.rd));
    check_val("illegal",   32'(illegal_d_o),    32'(is_illegal(op)));
    check_val("imm_src",   32'(imm_src_d_o),    32'(exp_imm(op)));
    check_val("alu_src",   32'(alu_src_e_o),    32'(m_ex.asrc));
    check_val("alu_a_pc",  32'(alu_a_pc_e_o),   32'(m_ex.apc));
    check_val("alu_ctrl",  32'(alu_ctrl_e_o),   32'(m_ex.alu));
    check_val("pc_src",    32'(pc_src_e_o),     32'(pcs));
    check_val("fwd_a",     32'(forward_a_e_o),  32'(fwd(m_ex.rs1)));
    check_val("fwd_b",     32'(forward_b_e_o),  32'(fwd(m_ex.rs2)));
    check_val("mem_wr_m",  32'(mem_write_m_o),  32'(m_mem.mw));
    check_val("reg_wr_m",  32'(reg_write_m_o),  32'(m_mem.rw));
    check_val("rd_m",      32'(rd_m_o),         32'(m_mem.rd));
    check_val("res_src_w", 32'(result_src_w_o), 32'(m_wb.rsrc));
    check_val("reg_wr_w",  32'(reg_write_w_o),  32'(m_wb.rw));
    check_val("rd_w",      32'(rd_w_o),         32'(m_wb.rd));
    check_val("stall_f",   32'(stall_f_o),      32'(lu && !redirect));
    check_val("stall_d",   32'(stall_d_o),      32'(lu && !redirect));
    check_val("flush_d",   32'(flush_d_o),      32'(redirect));
    obs_pc = pc_src_e_o; obs_flush = flush_d_o;
    obs_stall = stall_f_o; obs_illegal = illegal_d_o;
    exp_stall_last = lu && !redirect;
    m_wb  = m_mem;
    m_mem = m_ex;
    m_ex  = (lu || redirect) ? bubble() : to_slot(op);
    @(posedge clk);
    #1;
  endtask

  // Two reset cycles with add on the ID input; everything must read zero
  task automatic do_reset();
    rst = 1'b1;
    instr_d_i = encode(mk(K_R, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2));
    zero_e_i = 1'b1; lt_e_i = 1'b1; ltu_e_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_val("rst_pc_src",  32'(pc_src_e_o),    32'd0);
      check_val("rst_fwd",     32'({forward_a_e_o, forward_b_e_o}), 32'd0);
      check_val("rst_ex",      32'({alu_src_e_o, alu_a_pc_e_o, alu_ctrl_e_o}), 32'd0);
      check_val("rst_mem",     32'({mem_write_m_o, reg_write_m_o, rd_m_o}), 32'd0);
      check_val("rst_wb",      32'({result_src_w_o, reg_write_w_o, rd_w_o}), 32'd0);
      check_val("rst_hazard",  32'({stall_f_o, stall_d_o, flush_d_o}), 32'd0);
      check_val("rst_id",      32'({illegal_d_o, imm_src_d_o}), 32'd0);
    end
    rst = 1'b0;
    m_ex = bubble(); m_mem = bubble(); m_wb = bubble();
  endtask

  task automatic rand_op(output op_t op);
    op.kind = int'($urandom_range(0, 9));
    op.f3   = 3'($urandom_range(0, 7));
    op.f7b  = 1'($urandom_range(0, 1));
    op.rd   = 5'($urandom_range(0, 3));
    op.rs1  = 5'($urandom_range(0, 3));
    op.rs2  = 5'($urandom_range(0, 3));
    if (op.kind == K_LW || op.kind == K_SW) op.f3 = 3'd2;
    if (op.kind == K_JALR) op.f3 = 3'd0;
  endtask

  task automatic random_run(input int n);
    op_t cur;
    exp_stall_last = 1'b0;
    rand_op(cur);
    for (int i = 0; i < n; i++) begin
      // A stalled ID instruction is presented again, as IF/ID would hold it.
      if (!exp_stall_last) rand_op(cur);
      step(cur, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    op_t nop;
    nop = mk(K_I, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    rst = 1'b1; instr_d_i = 32'd0; zero_e_i = 1'b0; lt_e_i = 1'b0; ltu_e_i = 1'b0;
    do_reset();

    // add x3,x1,x2 ; sub x4,x3,x1 -> MEM forward
    step(mk(K_R, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0);
    step(mk(K_R, 3'd0, 1'b1, 5'd4, 5'd3, 5'd1), 1'b0, 1'b0, 1'b0);
    check_val("dir_fwd_mem", 32'(forward_a_e_o), 32'd2);
    check_val("dir_sub_alu", 32'(alu_ctrl_e_o), 32'(ALU_SUB));
    step(nop, 1'b0, 1'b0, 1'b0); step(nop, 1'b0, 1'b0, 1'b0);

    // add x3 ; nop ; sub x4,x3,x1 -> WB forward
    step(mk(K_R, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0);
    step(nop, 1'b0, 1'b0, 1'b0);
    step(mk(K_R, 3'd0, 1'b1, 5'd4, 5'd3, 5'd1), 1'b0, 1'b0, 1'b0);
    check_val("dir_fwd_wb", 32'(forward_a_e_o), 32'd1);
    step(nop, 1'b0, 1'b0, 1'b0); step(nop, 1'b0, 1'b0, 1'b0);

    // lw x5,0(x1) ; add x6,x5,x0 -> one stall cycle, then WB forward
    step(mk(K_LW, 3'd2, 1'b0, 5'd5, 5'd1, 5'd0), 1'b0, 1'b0, 1'b0);
    step(mk(K_R, 3'd0, 1'b0, 5'd6, 5'd5, 5'd0), 1'b0, 1'b0, 1'b0);
    check_val("dir_lu_stall", 32'(obs_stall), 32'd1);
    step(mk(K_R, 3'd0, 1'b0, 5'd6, 5'd5, 5'd0), 1'b0, 1'b0, 1'b0);
    check_val("dir_lu_release", 32'(obs_stall), 32'd0);
    check_val("dir_lu_bubble_m", 32'(reg_write_m_o), 32'd0);
    check_val("dir_lu_fwd_wb", 32'(forward_a_e_o), 32'd1);
    step(nop, 1'b0, 1'b0, 1'b0); step(nop, 1'b0, 1'b0, 1'b0);

    // beq taken / not taken, bgeu with ltu=0 taken
    step(mk(K_B, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0);
    step(nop, 1'b1, 1'b0, 1'b0);
    check_val("dir_beq_pc", 32'(obs_pc), 32'd1);
    check_val("dir_beq_flush", 32'(obs_flush), 32'd1);
    check_val("dir_beq_bubble", 32'(alu_src_e_o), 32'd0);
    step(mk(K_B, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0);
    step(nop, 1'b0, 1'b0, 1'b0);
    check_val("dir_beq_nt_flush", 32'(obs_flush), 32'd0);
    step(mk(K_B, 3'd7, 1'b0, 5'd0, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0);
    step(nop, 1'b0, 1'b1, 1'b0);
    check_val("dir_bgeu_pc", 32'(obs_pc), 32'd1);

    // jalr x1,0(x2) -> pc_src 10, then WB writes pc+4 to x1
    step(mk(K_JALR, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0), 1'b0, 1'b0, 1'b0);
    step(nop, 1'b0, 1'b0, 1'b0);
    check_val("dir_jalr_pc", 32'(obs_pc), 32'd2);
    step(nop, 1'b0, 1'b0, 1'b0);
    check_val("dir_jalr_res_w", 32'(result_src_w_o), 32'd2);
    check_val("dir_jalr_rw_w", 32'(reg_write_w_o), 32'd1);
    check_val("dir_jalr_rd_w", 32'(rd_w_o), 32'd1);

    // Illegal opcode and illegal branch funct3
    step(mk(K_BAD, 3'd0, 1'b0, 5'd7, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0);
    check_val("dir_bad_op", 32'(obs_illegal), 32'd1);
    step(mk(K_B, 3'd2, 1'b0, 5'd7, 5'd1, 5'd2), 1'b1, 1'b1, 1'b1);
    check_val("dir_bad_f3", 32'(obs_illegal), 32'd1);
    check_val("dir_bad_rw_m", 32'(reg_write_m_o), 32'd0);
    step(nop, 1'b1, 1'b1, 1'b1);
    check_val("dir_bad_nobranch", 32'(obs_pc), 32'd0);
    check_val("dir_bad_mw_m", 32'(mem_write_m_o), 32'd0);

    random_run(300);
    do_reset();
    random_run(300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
